// File: rtl/fp16_pkg.sv
// Shared FP16 constants, accumulator state encoding and field helpers used by
// the streaming accumulator and its adder.
package fp16_pkg;

  localparam int DWIDTH = 16;
  localparam int EWIDTH = 5;
  localparam int MWIDTH = 10;
  localparam int RWIDTH = 3;

  localparam logic [DWIDTH-1:0] FP16_POS_ZERO = 16'h0000;
  localparam logic [DWIDTH-1:0] FP16_QNAN     = 16'h7E00;
  localparam logic [EWIDTH-1:0] EXP_ALL1      = 5'h1F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_t;

  function automatic logic [EWIDTH-1:0] fp_exp(input logic [DWIDTH-1:0] x);
    return x[DWIDTH-2 -: EWIDTH];
  endfunction

  function automatic logic fp_is_inf(input logic [DWIDTH-1:0] x);
    return (fp_exp(x) == EXP_ALL1) && (x[MWIDTH-1:0] == 10'd0);
  endfunction

  function automatic logic fp_is_nan(input logic [DWIDTH-1:0] x);
    return (fp_exp(x) == EXP_ALL1) && (x[MWIDTH-1:0] != 10'd0);
  endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational IEEE-754 half-precision adder, round-to-nearest-even, with
// subnormal support; Exception flags Inf/NaN operands and overflow.
module fp16_add
  import fp16_pkg::*;
(
  input  logic [DWIDTH-1:0] a_operand,
  input  logic [DWIDTH-1:0] b_operand,
  output logic [DWIDTH-1:0] result,
  output logic              Exception
);

  localparam int XW = MWIDTH + 1 + RWIDTH;

  logic              swap_s;
  logic [DWIDTH-1:0] big_s;
  logic [DWIDTH-1:0] small_s;
  logic [EWIDTH-1:0] e_big_s;
  logic [EWIDTH-1:0] e_small_s;
  logic [EWIDTH-1:0] d_s;
  logic [EWIDTH-1:0] sh_s;
  logic [XW-1:0]     m_big_s;
  logic [XW-1:0]     m_small_s;
  logic [XW-1:0]     m_sh_s;
  logic [XW-1:0]     norm_s;
  logic [XW:0]       sum_s;
  logic [3:0]        lz_s;
  logic [6:0]        e_n_s;
  logic [6:0]        e_f_s;
  logic [MWIDTH+1:0] m_r_s;
  logic [MWIDTH-1:0] m_f_s;
  logic              rnd_s;

  // Align, add/subtract, normalise, round and select special cases.
  always_comb begin
    swap_s    = b_operand[DWIDTH-2:0] > a_operand[DWIDTH-2:0];
    big_s     = swap_s ? b_operand : a_operand;
    small_s   = swap_s ? a_operand : b_operand;
    e_big_s   = (fp_exp(big_s) == 5'd0) ? 5'd1 : fp_exp(big_s);
    e_small_s = (fp_exp(small_s) == 5'd0) ? 5'd1 : fp_exp(small_s);
    m_big_s   = {(fp_exp(big_s) != 5'd0), big_s[MWIDTH-1:0], 3'b000};
    m_small_s = {(fp_exp(small_s) != 5'd0), small_s[MWIDTH-1:0], 3'b000};
    d_s       = e_big_s - e_small_s;

    // Bits shifted past the round position collapse into the sticky lsb.
    if (d_s >= 5'd14) begin
      m_sh_s = {{(XW-1){1'b0}}, |m_small_s};
    end else begin
      m_sh_s = (m_small_s >> d_s) |
               {{(XW-1){1'b0}}, |(m_small_s & ~({XW{1'b1}} << d_s))};
    end

    if (big_s[DWIDTH-1] == small_s[DWIDTH-1]) begin
      sum_s = {1'b0, m_big_s} + {1'b0, m_sh_s};
    end else begin
      sum_s = {1'b0, m_big_s} - {1'b0, m_sh_s};
    end

    lz_s = 4'd14;
    for (int i = 0; i < XW; i++) begin
      if (sum_s[i]) begin
        lz_s = 4'(XW - 1 - i);
      end else begin
        lz_s = lz_s;
      end
    end
    sh_s = ({1'b0, lz_s} < (e_big_s - 5'd1)) ? {1'b0, lz_s} : (e_big_s - 5'd1);

    if (sum_s[XW]) begin
      norm_s = sum_s[XW:1] | {{(XW-1){1'b0}}, sum_s[0]};
      e_n_s  = {2'b00, e_big_s} + 7'd1;
    end else begin
      norm_s = sum_s[XW-1:0] << sh_s;
      e_n_s  = norm_s[XW-1] ? ({2'b00, e_big_s} - {2'b00, sh_s}) : 7'd0;
    end

    rnd_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    m_r_s = {1'b0, norm_s[XW-1:RWIDTH]} + {{(MWIDTH+1){1'b0}}, rnd_s};

    if (m_r_s[MWIDTH+1]) begin
      e_f_s = e_n_s + 7'd1;
      m_f_s = m_r_s[MWIDTH:1];
    end else if ((e_n_s == 7'd0) && m_r_s[MWIDTH]) begin
      e_f_s = 7'd1;
      m_f_s = m_r_s[MWIDTH-1:0];
    end else begin
      e_f_s = e_n_s;
      m_f_s = m_r_s[MWIDTH-1:0];
    end

    if (fp_is_nan(a_operand) || fp_is_nan(b_operand) ||
        (fp_is_inf(a_operand) && fp_is_inf(b_operand) &&
         (a_operand[DWIDTH-1] != b_operand[DWIDTH-1]))) begin
      result    = FP16_QNAN;
      Exception = 1'b1;
    end else if (fp_is_inf(a_operand)) begin
      result    = a_operand;
      Exception = 1'b1;
    end else if (fp_is_inf(b_operand)) begin
      result    = b_operand;
      Exception = 1'b1;
    end else if (sum_s == 15'd0) begin
      result    = {a_operand[DWIDTH-1] & b_operand[DWIDTH-1], 15'd0};
      Exception = 1'b0;
    end else if (e_f_s >= 7'd31) begin
      result    = {big_s[DWIDTH-1], EXP_ALL1, 10'd0};
      Exception = 1'b1;
    end else begin
      result    = {big_s[DWIDTH-1], e_f_s[EWIDTH-1:0], m_f_s};
      Exception = 1'b0;
    end
  end

endmodule

// File: rtl/fp16_acc_stream.sv
// Streaming FP16 accumulator: sums a packet of samples through fp16_add and
// presents sum, saturating count and sticky exception on a valid/ready output.
module fp16_acc_stream
  import fp16_pkg::*;
#(
  parameter int CWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_sum,
  output logic [CWIDTH-1:0] out_count,
  output logic              out_exception
);

  localparam logic [CWIDTH-1:0] CNT_MAX  = {CWIDTH{1'b1}};
  localparam logic [CWIDTH-1:0] CNT_ONE  = CWIDTH'(1);
  localparam logic [CWIDTH-1:0] CNT_ZERO = CWIDTH'(0);

  acc_state_t        state_r;
  logic [DWIDTH-1:0] sum_r;
  logic [CWIDTH-1:0] cnt_r;
  logic              exc_r;
  logic              valid_r;
  logic [DWIDTH-1:0] add_res_s;
  logic              add_exc_s;
  logic              accept_s;

  fp16_add u_add (
    .a_operand (sum_r),
    .b_operand (in_data),
    .result    (add_res_s),
    .Exception (add_exc_s)
  );

  assign in_ready = ~rst & ~flush & (state_r != HOLD);
  assign accept_s = in_valid & in_ready;

  // Packet FSM with running sum, saturating count and sticky exception.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_r <= IDLE;
      sum_r   <= FP16_POS_ZERO;
      cnt_r   <= CNT_ZERO;
      exc_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, ACC: begin
          if (accept_s) begin
            sum_r   <= add_res_s;
            exc_r   <= exc_r | add_exc_s;
            cnt_r   <= (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
            state_r <= in_last ? HOLD : ACC;
            valid_r <= in_last;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_r <= IDLE;
            sum_r   <= FP16_POS_ZERO;
            cnt_r   <= CNT_ZERO;
            exc_r   <= 1'b0;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid     = valid_r;
  assign out_sum       = sum_r;
  assign out_count     = cnt_r;
  assign out_exception = exc_r;

endmodule

// File: tb/tb_fp16_acc_stream.sv
// Self-checking bench for fp16_acc_stream: directed packets followed by random
// traffic, checked against a real-arithmetic FP16 reference model.
module tb_fp16_acc_stream;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_last, out_ready;
  logic [15:0] in_data;
  logic        ir8, ov8, exc8, ir2, ov2, exc2;
  logic [15:0] sum8, sum2;
  logic [7:0]  cnt8;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit          m_init = 1'b0;
  bit          m_hold = 1'b0;
  logic [15:0] m_sum  = 16'h0000;
  int          m_cnt  = 0;
  bit          m_exc  = 1'b0;

  always #5 clk = ~clk;

  fp16_acc_stream #(.CWIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir8),
    .in_data(in_data), .in_last(in_last), .out_valid(ov8), .out_ready(out_ready),
    .out_sum(sum8), .out_count(cnt8), .out_exception(exc8)
  );

  fp16_acc_stream #(.CWIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
    .out_sum(sum2), .out_count(cnt2), .out_exception(exc2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real p2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real to_real(input logic [15:0] h);
    int  e = int'(h[14:10]);
    int  m = int'(h[9:0]);
    real v = (e == 0) ? m * p2(-24) : (1024 + m) * p2(e - 25);
    return h[15] ? -v : v;
  endfunction

  // Exact sum in double precision, then rounded once to FP16 (nearest-even).
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    bit  a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    bit  b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    bit  a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    bit  b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    real x, y, q, frac;
    int  e, n;
    bit  s;
    if (a_nan || b_nan || (a_inf && b_inf && a[15] != b[15])) return {1'b1, 16'h7E00};
    if (a_inf) return {1'b1, a};
    if (b_inf) return {1'b1, b};
    x = to_real(a) + to_real(b);
    if (x == 0.0) return {1'b0, a[15] & b[15], 15'd0};
    s = (x < 0.0);
    y = s ? -x : x;
    e = 0;
    while (y >= p2(e + 1)) e++;
    while (e > -14 && y < p2(e)) e--;
    q = y / p2(e - 10);
    n = $rtoi(q);
    frac = q - n;
    if (frac > 0.5 || (frac == 0.5 && (n % 2) == 1)) n++;
    if (n == 2048) begin
      n = 1024;
      e++;
    end
    if (e > 15) return {1'b1, s, 5'h1F, 10'd0};
    if (n < 1024) return {1'b0, s, 5'd0, 10'(n)};
    return {1'b0, s, 5'(e + 15), 10'(n - 1024)};
  endfunction

  function automatic logic [15:0] rand_fp16();
    int k = $urandom % 64;
    logic [15:0] v;
    v = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
    if (k == 0) v = {1'($urandom), 15'h7C00};
    else if (k == 1) v = {1'($urandom), 5'h1F, 10'($urandom_range(1, 1023))};
    else if (k == 2) v = {1'($urandom), 15'd0};
    else if (k == 3) v = {1'($urandom), 5'd0, 10'($urandom)};
    else if (k == 4) v = {1'b0, 5'd30, 10'($urandom)};
    return v;
  endfunction

  task automatic drive(input logic rs, input logic f, input logic v,
                       input logic [15:0] d, input logic l, input logic r);
    logic exp_ready;
    @(negedge clk);
    rst = rs; flush = f; in_valid = v; in_data = d; in_last = l; out_ready = r;
    #1;
    exp_ready = !rs && !f && !m_hold;
    check_eq("in_ready8", 32'(ir8), 32'(exp_ready));
    check_eq("in_ready2", 32'(ir2), 32'(exp_ready));
    if (!rs && m_init) begin
      check_eq("out_valid8", 32'(ov8), 32'(m_hold));
      check_eq("out_valid2", 32'(ov2), 32'(m_hold));
      if (m_hold || m_cnt == 0) begin
        check_eq("out_sum8", 32'(sum8), 32'(m_sum));
        check_eq("out_sum2", 32'(sum2), 32'(m_sum));
        check_eq("out_count8", 32'(cnt8), (m_cnt > 255) ? 32'd255 : 32'(m_cnt));
        check_eq("out_count2", 32'(cnt2), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
        check_eq("out_exc8", 32'(exc8), 32'(m_exc));
        check_eq("out_exc2", 32'(exc2), 32'(m_exc));
      end
    end
  endtask

  task automatic tick();
    logic [16:0] r;
    @(posedge clk);
    if (rst || flush) begin
      m_init = 1'b1; m_hold = 1'b0; m_sum = 16'h0000; m_cnt = 0; m_exc = 1'b0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0; m_sum = 16'h0000; m_cnt = 0; m_exc = 1'b0;
      end
    end else if (in_valid) begin
      r = ref_add(m_sum, in_data);
      m_sum = r[15:0];
      m_exc = m_exc | r[16];
      m_cnt++;
      if (in_last) m_hold = 1'b1;
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic l);
    drive(1'b0, 1'b0, 1'b1, d, l, 1'b0);
    tick();
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, 16'h3C00, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check_eq("rst_sum", 32'(sum8), 32'h0000);
    check_eq("rst_valid", 32'(ov8), 32'd0);
    tick();

    // single-sample packet
    beat(16'h5719, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("t1_valid", 32'(ov8), 32'd1);
    check_eq("t1_sum", 32'(sum8), 32'h5719);
    check_eq("t1_count", 32'(cnt8), 32'd1);
    check_eq("t1_exc", 32'(exc8), 32'd0);
    tick();

    // two-sample common add
    beat(16'h5719, 1'b0);
    beat(16'h4741, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("t2_sum", 32'(sum8), 32'h578D);
    check_eq("t2_count", 32'(cnt8), 32'd2);
    tick();

    // normalising add under back-pressure
    beat(16'h5719, 1'b0);
    beat(16'h4B41, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 16'h3C00, 1'b0, 1'b0);
      check_eq("t3_sum", 32'(sum8), 32'h5801);
      check_eq("t3_count", 32'(cnt8), 32'd2);
      check_eq("t3_ready", 32'(ir8), 32'd0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check_eq("t3_ready_back", 32'(ir8), 32'd1);
    tick();

    // flush mid-packet, beat in the flush cycle is dropped
    beat(16'h5719, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 16'h4741, 1'b0, 1'b0);
    check_eq("t4_flush_ready", 32'(ir8), 32'd0);
    tick();
    beat(16'h4741, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("t4_sum", 32'(sum8), 32'h4741);
    check_eq("t4_count", 32'(cnt8), 32'd1);
    tick();

    // exception, saturation, sticky clear
    beat(16'h7C00, 1'b0);
    beat(16'h3C00, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("t5_exc", 32'(exc2), 32'd1);
    tick();
    for (int i = 0; i < 5; i++) beat(16'h3C00, (i == 4));
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("t5_sat2", 32'(cnt2), 32'd3);
    check_eq("t5_cnt8", 32'(cnt8), 32'd5);
    check_eq("t5_sum", 32'(sum8), 32'h4500);
    tick();
    beat(16'h3C00, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("t5_exc_clear", 32'(exc2), 32'd0);
    tick();

    // negative zero collapses to +0
    beat(16'h8000, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("negzero_sum", 32'(sum8), 32'h0000);
    tick();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      drive(($urandom % 700) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
            rand_fp16(), ($urandom % 4) == 0, ($urandom % 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
